// File: rtl/pipe_stage_chain.sv
// -----------------------------------------------------------------------------
// pipe_stage_chain
//
// Purpose:
//   A chain of DEPTH valid/ready register stages carrying a WIDTH-bit payload.
//   Each stage is ready when it is empty (after its flush bit is applied) or
//   when the stage downstream of it is ready. Because of this, empty stages
//   absorb data while the output is stalled. A per-stage flush mask removes
//   items in place. A flushed item never moves forward, and a stage that is
//   being flushed can still accept a new item in the same cycle.
//
// Parameters:
//   WIDTH  payload width in bits (1..256)
//   DEPTH  number of register stages (1..8); stage 0 is the input side
//
// Ports:
//   CLK        rising-edge clock for all state
//   RST        synchronous active-high reset
//   in_valid   upstream offers in_data this cycle
//   in_data    upstream payload
//   in_ready   stage 0 accepts this cycle
//   out_valid  last stage holds a live (unflushed) item
//   out_data   last stage payload
//   out_ready  downstream consumes this cycle
//   flush      per-stage kill mask; bit k kills the item in stage k
//   occupancy  number of registered valid bits (before flush takes effect)
//   stall_cnt  cycles with out_valid=1 and out_ready=0 (saturating)
//   flush_cnt  number of items killed by flush (saturating)
//
// Configuration:
//   PIPE_CHAIN_PERF_EN  when defined, stall_cnt and flush_cnt are live
//                       counters. When undefined, both ports are tied to 0
//                       and no counter logic exists.
// -----------------------------------------------------------------------------
module pipe_stage_chain #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ready,
    input  logic [DEPTH-1:0]             flush,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [31:0]                  stall_cnt,
    output logic [31:0]                  flush_cnt
);

    localparam int unsigned OccW = $clog2(DEPTH + 1);

    // Stage state
    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    // Combinational stage controls
    logic [DEPTH-1:0] eff_valid;
    logic [DEPTH-1:0] ready;
    logic             ready_acc;
    logic [DEPTH-1:0] src_valid;
    logic [WIDTH-1:0] src_data [DEPTH];
    logic [OccW-1:0]  occ_sum;

    // A flushed stage looks empty to both its neighbours.
    always_comb begin
        eff_valid = valid_q & ~flush;
    end

    // ready_k = !ev_k | ready_(k+1). This is computed as a running OR from
    // the output side so that the ready vector does not depend on itself.
    always_comb begin
        ready_acc = out_ready;
        ready     = '0;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            ready_acc = ready_acc | ~eff_valid[k];
            ready[k]  = ready_acc;
        end
    end

    // Source of each stage: the upstream port for stage 0, otherwise the
    // previous stage. The previous stage's effective valid is used, so a
    // flushed item is never forwarded.
    always_comb begin
        src_valid    = '0;
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        for (int k = 1; k < int'(DEPTH); k++) begin
            src_valid[k] = eff_valid[k-1];
            src_data[k]  = data_q[k-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                if (ready[k]) begin
                    // A stage with flush set is always ready (ev_k = 0), so a
                    // new item can replace the killed one in the same cycle.
                    valid_q[k] <= src_valid[k];
                    if (src_valid[k]) begin
                        data_q[k] <= src_data[k];
                    end
                end
            end
        end
    end

    // Occupancy counts registered valid bits. Flush only shows up after
    // the clock edge.
    always_comb begin
        occ_sum = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            occ_sum = occ_sum + OccW'(valid_q[k]);
        end
    end

    always_comb begin
        in_ready  = ready[0];
        out_valid = eff_valid[DEPTH-1];
        out_data  = data_q[DEPTH-1];
        occupancy = occ_sum;
    end

`ifdef PIPE_CHAIN_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;
    logic [3:0]  kill_num;
    logic [32:0] flush_sum;

    // DEPTH <= 8, so the per-cycle kill count fits in 4 bits.
    always_comb begin
        kill_num = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            kill_num = kill_num + 4'(valid_q[k] & flush[k]);
        end
    end

    always_comb begin
        flush_sum = {1'b0, flush_cnt_q} + 33'(kill_num);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            flush_cnt_q <= flush_sum[32] ? 32'hFFFF_FFFF : flush_sum[31:0];
        end
    end

    always_comb begin
        stall_cnt = stall_cnt_q;
        flush_cnt = flush_cnt_q;
    end
`else
    always_comb begin
        stall_cnt = '0;
        flush_cnt = '0;
    end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
module tb_pipe_stage_chain;

`ifdef PIPE_CHAIN_PERF_EN
    localparam bit Perf = 1'b1;
`else
    localparam bit Perf = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    // DEPTH=4, WIDTH=32 instance
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [3:0]  flush;
    logic [2:0]  occupancy;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    // DEPTH=1, WIDTH=8 instance
    logic        in_valid1;
    logic [7:0]  in_data1;
    logic        in_ready1;
    logic        out_valid1;
    logic [7:0]  out_data1;
    logic        out_ready1;
    logic [0:0]  flush1;
    logic [0:0]  occupancy1;
    logic [31:0] stall_cnt1;
    logic [31:0] flush_cnt1;

    int checks = 0;
    int errors = 0;
    logic [31:0] got[$];

    always #5 clk = ~clk;

    pipe_stage_chain #(.WIDTH(32), .DEPTH(4)) dut (
        .CLK(clk), .RST(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .flush(flush), .occupancy(occupancy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_chain #(.WIDTH(8), .DEPTH(1)) dut1 (
        .CLK(clk), .RST(rst),
        .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready1),
        .flush(flush1), .occupancy(occupancy1),
        .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = '0;
        in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0; flush1 = '0;
        tick();
        rst = 1'b0;
    endtask

    // Push one item with the given out_ready, no checks.
    task automatic push(input logic [31:0] d, input logic ordy);
        in_valid = 1'b1; in_data = d; out_ready = ordy; flush = '0;
        tick();
        in_valid = 1'b0;
    endtask

    // Drain for a bounded number of cycles, recording every transfer.
    task automatic collect(input int budget);
        in_valid = 1'b0; out_ready = 1'b1; flush = '0;
        for (int i = 0; i < budget; i++) begin
            #1;
            if (out_valid) got.push_back(out_data);
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++;
            $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (occupancy !== 3'd0) begin errors++;
            $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        checks++; if (out_data !== 32'd0) begin errors++;
            $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin errors++;
            $display("FAIL reset_counters got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
        checks++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin errors++;
            $display("FAIL reset_d1 got v=%0b r=%0b want v=0 r=1", out_valid1, in_ready1); end
    endtask

    // 0x1..0x8 back to back: first output 4 cycles after first accept, no gaps.
    task automatic test_stream();
        logic exp_v;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            in_valid = (c < 8); in_data = 32'(c + 1); out_ready = 1'b1; flush = '0;
            #1;
            exp_v = (c >= 4) && (c < 12);
            checks++; if (in_ready !== 1'b1) begin errors++;
                $display("FAIL stream_in_ready c=%0d got %0b want 1", c, in_ready); end
            checks++; if (out_valid !== exp_v) begin errors++;
                $display("FAIL stream_out_valid c=%0d got %0b want %0b", c, out_valid, exp_v); end
            if (exp_v) begin
                checks++; if (out_data !== 32'(c - 3)) begin errors++;
                    $display("FAIL stream_data c=%0d got %h want %h", c, out_data, c - 3); end
            end
            tick();
        end
    endtask

    // Fill with out_ready low, then release for exactly one cycle.
    task automatic test_full_stall();
        do_reset();
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i), 1'b0);
        in_valid = 1'b1; in_data = 32'hEE; out_ready = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd4) begin errors++;
            $display("FAIL full_occupancy got %0d want 4", occupancy); end
        checks++; if (in_ready !== 1'b0) begin errors++;
            $display("FAIL full_in_ready got %0b want 0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hA0) begin errors++;
            $display("FAIL full_head got v=%0b d=%h want v=1 d=a0", out_valid, out_data); end
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL release_in_ready got %0b want 1", in_ready); end
        tick();
        out_ready = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd3) begin errors++;
            $display("FAIL release_occupancy got %0d want 3", occupancy); end
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hA1) begin errors++;
            $display("FAIL release_next got v=%0b d=%h want v=1 d=a1", out_valid, out_data); end
        // Stalled exactly one cycle (the held cycle) before the release.
        checks++; if (stall_cnt !== (Perf ? 32'd1 : 32'd0)) begin errors++;
            $display("FAIL stall_cnt got %0d want %0d", stall_cnt, Perf ? 1 : 0); end
    endtask

    // A in stage 3, B in stage 1, stage 2 empty; C enters while output stalled.
    task automatic test_bubble();
        do_reset();
        push(32'hA, 1'b0);
        tick();
        push(32'hB, 1'b0);
        tick();
        #1;
        checks++; if (occupancy !== 3'd2) begin errors++;
            $display("FAIL bubble_setup_occ got %0d want 2", occupancy); end
        in_valid = 1'b1; in_data = 32'hC; out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL bubble_in_ready got %0b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (occupancy !== 3'd3) begin errors++;
            $display("FAIL bubble_occupancy got %0d want 3", occupancy); end
        checks++; if (out_data !== 32'hA) begin errors++;
            $display("FAIL bubble_head got %h want a", out_data); end
        got.delete();
        collect(10);
        checks++; if (got.size() != 3) begin errors++;
            $display("FAIL bubble_count got %0d want 3", got.size()); end
        else begin
            checks++; if (got[0] !== 32'hA || got[1] !== 32'hB || got[2] !== 32'hC) begin
                errors++;
                $display("FAIL bubble_order got %h %h %h want a b c", got[0], got[1], got[2]);
            end
        end
    endtask

    // Full chain, flush stages 1 and 2 for one cycle with out_ready high.
    task automatic test_flush();
        do_reset();
        push(32'h11, 1'b0); push(32'h22, 1'b0); push(32'h33, 1'b0); push(32'h44, 1'b0);
        got.delete();
        in_valid = 1'b0; out_ready = 1'b1; flush = 4'b0110;
        #1;
        checks++; if (occupancy !== 3'd4) begin errors++;
            $display("FAIL flush_occ_before_edge got %0d want 4", occupancy); end
        if (out_valid) got.push_back(out_data);
        tick();
        flush = '0;
        collect(8);
        checks++; if (got.size() != 2) begin errors++;
            $display("FAIL flush_count got %0d want 2", got.size()); end
        else begin
            checks++; if (got[0] !== 32'h11 || got[1] !== 32'h44) begin errors++;
                $display("FAIL flush_items got %h %h want 11 44", got[0], got[1]); end
        end
        checks++; if (flush_cnt !== (Perf ? 32'd2 : 32'd0)) begin errors++;
            $display("FAIL flush_cnt got %0d want %0d", flush_cnt, Perf ? 2 : 0); end
    endtask

    // Flush stage 1 while stage 0's item moves into it: the new item survives.
    task automatic test_flush_entry();
        do_reset();
        push(32'h50, 1'b0);
        push(32'h51, 1'b0);
        in_valid = 1'b0; out_ready = 1'b0; flush = 4'b0010;
        tick();
        flush = '0;
        #1;
        checks++; if (occupancy !== 3'd1) begin errors++;
            $display("FAIL flush_entry_occ got %0d want 1", occupancy); end
        got.delete();
        collect(8);
        checks++; if (got.size() != 1 || got[0] !== 32'h51) begin errors++;
            $display("FAIL flush_entry_item got n=%0d want 1 item 51", got.size()); end
    endtask

    // Reset with a full, stalled chain; nothing may come out afterwards.
    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 4; i++) push(32'h70 + 32'(i), 1'b0);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || occupancy !== 3'd0) begin errors++;
            $display("FAIL rst_mid_state got v=%0b occ=%0d want 0 0", out_valid, occupancy); end
        checks++; if (in_ready !== 1'b1) begin errors++;
            $display("FAIL rst_mid_in_ready got %0b want 1", in_ready); end
        checks++; if (stall_cnt !== 32'd0) begin errors++;
            $display("FAIL rst_mid_stall_cnt got %0d want 0", stall_cnt); end
        got.delete();
        collect(8);
        checks++; if (got.size() != 0) begin errors++;
            $display("FAIL rst_mid_leak got %0d items want 0", got.size()); end
    endtask

    // DEPTH=1: one item per cycle, 1-cycle latency.
    task automatic test_depth1();
        do_reset();
        out_ready1 = 1'b1; in_valid1 = 1'b1; in_data1 = 8'h55;
        #1;
        checks++; if (out_valid1 !== 1'b0) begin errors++;
            $display("FAIL d1_c0_valid got %0b want 0", out_valid1); end
        tick();
        in_data1 = 8'hAA;
        #1;
        checks++; if (out_valid1 !== 1'b1 || out_data1 !== 8'h55 || in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL d1_c1 got v=%0b d=%h r=%0b want 1 55 1",
                     out_valid1, out_data1, in_ready1);
        end
        tick();
        in_valid1 = 1'b0;
        #1;
        checks++; if (out_valid1 !== 1'b1 || out_data1 !== 8'hAA) begin errors++;
            $display("FAIL d1_c2 got v=%0b d=%h want 1 aa", out_valid1, out_data1); end
        tick();
        #1;
        checks++; if (out_valid1 !== 1'b0) begin errors++;
            $display("FAIL d1_c3_valid got %0b want 0", out_valid1); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full_stall();
        test_bubble();
        test_flush();
        test_flush_entry();
        test_reset_midstream();
        test_depth1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits per stage; legal range 1..256.
REQ-002 Parameter DEPTH, default 4: number of register stages; legal range 1..8. Stage 0 is input side, stage DEPTH-1 is output side.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset, on ports CLK and RST.
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 in_ready  output  1  stage 0 accepts this cycle.
REQ-009 out_valid  output  1  stage DEPTH-1 holds a live item.
REQ-010 out_data  output  WIDTH  stage DEPTH-1 payload.
REQ-011 out_ready  input  1  downstream consumes this cycle.
REQ-012 flush  input  DEPTH  per-stage kill mask; bit k kills the stage k item.
REQ-013 occupancy  output  $clog2(DEPTH+1)  count of registered valid bits.
REQ-014 stall_cnt  output  32  perf: output-stall cycles (see Configuration).
REQ-015 flush_cnt  output  32  perf: killed items (see Configuration).

Function
REQ-016 Each stage k SHALL hold registers valid_k and data_k; effective valid ev_k = valid_k AND NOT flush[k].
REQ-017 Stage readiness SHALL be ready_k = NOT ev_k OR ready_(k+1), with ready_DEPTH = out_ready; in_ready = ready_0, all combinational.
REQ-018 On a clock edge with ready_k high, valid_k SHALL load ev_(k-1) (in_valid for k=0) and data_k SHALL load data_(k-1) (in_data for k=0) only when that source is valid; otherwise data_k holds.
REQ-019 With ready_k low, stage k SHALL hold valid_k and data_k unchanged.
REQ-020 A flushed item SHALL never propagate: with flush[k] high, stage k forwards nothing, and valid_k is cleared next cycle unless a new item enters stage k.
REQ-021 out_valid = ev_(DEPTH-1) and out_data = data_(DEPTH-1); a transfer occurs when out_valid AND out_ready.
REQ-022 Bubbles SHALL collapse: an empty stage accepts upstream data even while downstream is stalled.
REQ-023 Latency SHALL be DEPTH cycles from in_valid AND in_ready to out_valid for an uncontended chain; throughput one item per cycle.
REQ-024 Items SHALL leave in acceptance order; no duplication and no loss except by flush.
REQ-025 occupancy SHALL equal the popcount of registered valid_0..valid_(DEPTH-1) (flush does not alter it until the edge).
REQ-026 Full chain with out_ready low and flush all-zero SHALL drive in_ready low; an empty chain SHALL drive out_valid low.
REQ-027 Simultaneous flush[k] and entry into stage k from k-1 SHALL keep the entering item (flush acts on current contents only).

Reset
REQ-028 RST high at a clock edge SHALL clear every valid_k, giving out_valid=0, occupancy=0, in_ready=1 in the following cycle; RST dominates all other inputs.
REQ-029 data_k registers SHALL clear to 0 on reset.
REQ-030 stall_cnt and flush_cnt SHALL clear to 0 on reset; reset mid-stream SHALL discard all in-flight items without emitting any.

Configuration
REQ-031 With PIPE_CHAIN_PERF_EN defined, stall_cnt SHALL increment each cycle out_valid=1 and out_ready=0, and flush_cnt SHALL add the popcount of (valid AND flush) each cycle; both saturate at 32'hFFFFFFFF.
REQ-032 Without PIPE_CHAIN_PERF_EN, stall_cnt and flush_cnt SHALL be constant 0, with no counter logic instantiated; ports remain present.

Verification (WIDTH=32, DEPTH=4 unless noted)
REQ-033 Stream 0x1..0x8 on consecutive cycles, out_ready=1 -> first out_valid 4 cycles after first accept, values 0x1..0x8 in order, no gaps.
REQ-034 Fill 4 items with out_ready=0 -> occupancy=4, in_ready=0; raise out_ready one cycle -> exactly one item out, in_ready=1 that same cycle.
REQ-035 Items A,B in stages 3,1 (stage 2 empty), out_ready=0, in_valid with C -> C and B advance, A held; occupancy 3 next cycle.
REQ-036 Full chain, flush=4'b0110 one cycle, out_ready=1 -> only items from stages 3 and 0 emerge; flush_cnt=2 with PERF enabled, 0 without.
REQ-037 RST pulsed with chain full and out_ready=0 for 5 cycles -> next cycle out_valid=0, occupancy=0, in_ready=1, stall_cnt=0.
REQ-038 DEPTH=1, WIDTH=8: in_valid=1, out_ready=1 continuous with 0x55,0xAA -> one item per cycle, 1-cycle latency.
